// File: rtl/fifo_param_pkg.sv
// Shared sizing helpers and the error-flag struct for the parametrised FIFO.
package fifo_param_pkg;

    function automatic int cnt_width(input int entries);
        return $clog2(entries + 1);
    endfunction

    function automatic int ptr_width(input int entries);
        return ($clog2(entries) < 1) ? 1 : $clog2(entries);
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

endpackage

// File: rtl/fifo_ptr.sv
// Circular index register: advances on en, wraps from ENTRIES-1 back to 0.
module fifo_ptr
    import fifo_param_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int PTR_W   = ptr_width(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);

    // Explicit compare so non-power-of-two depths wrap correctly.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (en)
            ptr <= (ptr == PTR_W'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/fifo_param.sv
// Synchronous FWFT FIFO with arbitrary depth, thresholds, occupancy count
// and sticky overflow/underflow flags.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int ENTRIES       = 4,
    parameter int AFULL_THRESH  = ENTRIES - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_write_ctrl,
    input  logic [WIDTH-1:0]               in_write_data,
    input  logic                           in_read_ctrl,
    input  logic                           in_clear_err,
    output logic [WIDTH-1:0]               out_read_data,
    output logic                           out_is_full,
    output logic                           out_is_empty,
    output logic                           out_almost_full,
    output logic                           out_almost_empty,
    output logic [cnt_width(ENTRIES)-1:0]  out_count,
    output logic                           out_overflow,
    output logic                           out_underflow
);

    localparam int CNT_W = cnt_width(ENTRIES);
    localparam int PTR_W = ptr_width(ENTRIES);

    logic [WIDTH-1:0] mem [ENTRIES];
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    err_flags_t       err;
    logic             full, empty, push_acc, pop_acc;

    assign full     = (count == CNT_W'(ENTRIES));
    assign empty    = (count == '0);
    // A pop frees a slot in the same edge, so a full FIFO still takes a push.
    assign push_acc = in_write_ctrl && (!full || in_read_ctrl);
    assign pop_acc  = in_read_ctrl && !empty;

    fifo_ptr #(.ENTRIES(ENTRIES), .PTR_W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (push_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.ENTRIES(ENTRIES), .PTR_W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (pop_acc),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (!rst && push_acc)
            mem[wr_ptr] <= in_write_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else
            count <= count + CNT_W'(push_acc) - CNT_W'(pop_acc);
    end

    // A fresh error in the clearing cycle keeps its flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= '0;
        end else begin
            err.overflow  <= (in_write_ctrl && !push_acc) || (err.overflow  && !in_clear_err);
            err.underflow <= (in_read_ctrl  && empty)     || (err.underflow && !in_clear_err);
        end
    end

    assign out_read_data    = empty ? '0 : mem[rd_ptr];
    assign out_is_full      = full;
    assign out_is_empty     = empty;
    assign out_almost_full  = (count >= CNT_W'(AFULL_THRESH));
    assign out_almost_empty = (count <= CNT_W'(AEMPTY_THRESH));
    assign out_count        = count;
    assign out_overflow     = err.overflow;
    assign out_underflow    = err.underflow;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (5 entries): scoreboard queue checks popped
// data in a monitor; status outputs are checked against hand-derived values.
module tb_fifo_param;

    localparam int WIDTH = 8;
    localparam int ENTRIES = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_write_ctrl = 1'b0;
    logic [WIDTH-1:0] in_write_data = '0;
    logic             in_read_ctrl = 1'b0;
    logic             in_clear_err = 1'b0;
    logic [WIDTH-1:0] out_read_data;
    logic             out_is_full, out_is_empty, out_almost_full, out_almost_empty;
    logic [2:0]       out_count;
    logic             out_overflow, out_underflow;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    fifo_param #(.WIDTH(WIDTH), .ENTRIES(ENTRIES), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_write_ctrl    (in_write_ctrl),
        .in_write_data    (in_write_data),
        .in_read_ctrl     (in_read_ctrl),
        .in_clear_err     (in_clear_err),
        .out_read_data    (out_read_data),
        .out_is_full      (out_is_full),
        .out_is_empty     (out_is_empty),
        .out_almost_full  (out_almost_full),
        .out_almost_empty (out_almost_empty),
        .out_count        (out_count),
        .out_overflow     (out_overflow),
        .out_underflow    (out_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; acc says whether the push is expected to be taken.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                        input logic clr, input logic acc);
        in_write_ctrl = w;
        in_write_data = d;
        in_read_ctrl  = r;
        in_clear_err  = clr;
        if (w && acc) exp_q.push_back(d);
        @(posedge clk);
        #1;
        in_write_ctrl = 1'b0;
        in_write_data = '0;
        in_read_ctrl  = 1'b0;
        in_clear_err  = 1'b0;
    endtask

    task automatic check_status(input string tag, input int cnt, input logic ov, input logic uf);
        check({tag, " count"}, 32'(out_count), 32'(cnt));
        check({tag, " empty"}, 32'(out_is_empty), 32'(cnt == 0));
        check({tag, " full"}, 32'(out_is_full), 32'(cnt == ENTRIES));
        check({tag, " afull"}, 32'(out_almost_full), 32'(cnt >= 4));
        check({tag, " aempty"}, 32'(out_almost_empty), 32'(cnt <= 1));
        check({tag, " overflow"}, 32'(out_overflow), 32'(ov));
        check({tag, " underflow"}, 32'(out_underflow), 32'(uf));
    endtask

    // Scoreboard monitor: a pop is taken whenever read is requested and not empty.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && in_read_ctrl && !out_is_empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_data: got 0x%0h expected nothing (queue empty)", out_read_data);
                end else begin
                    check("pop_data", 32'(out_read_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_status("reset", 0, 1'b0, 1'b0);
        check("reset rdata", 32'(out_read_data), 32'h0);

        // Fill 0x11..0x55
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 8'(i * 8'h11), 1'b0, 1'b0, 1'b1);
            check_status("fill", i, 1'b0, 1'b0);
            check("fill head", 32'(out_read_data), 32'h11);
        end

        // Overflow while full, then clear
        step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        check_status("ovf", 5, 1'b1, 1'b0);
        check("ovf head", 32'(out_read_data), 32'h11);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_status("ovf clr", 5, 1'b0, 1'b0);

        // Full push+pop: both accepted
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
        check_status("full pp", 5, 1'b0, 1'b0);
        check("full pp head", 32'(out_read_data), 32'h22);

        // Drain: 0x22,0x33,0x44,0x55,0xAA
        for (int i = 4; i >= 0; i--) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check_status("drain", i, 1'b0, 1'b0);
        end
        check("drain rdata", 32'(out_read_data), 32'h0);

        // Empty push+pop: pop ignored, underflow set
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        check_status("empty pp", 1, 1'b0, 1'b1);
        check("empty pp head", 32'(out_read_data), 32'h3C);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_status("uf clr", 1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_status("pop 3c", 0, 1'b0, 1'b0);
        // New underflow in the clearing cycle wins
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check_status("uf vs clr", 0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_status("uf clr2", 0, 1'b0, 1'b0);

        // Leave underflow set going into the wrap run
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        check_status("pre wrap", 3, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b1);
            check("wrap count", 32'(out_count), 32'd3);
        end
        check("wrap head", 32'(out_read_data), 32'h89);

        // Reset mid-stream with a push pending
        rst = 1'b1;
        in_write_ctrl = 1'b1;
        in_write_data = 8'hEE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_write_ctrl = 1'b0;
        exp_q.delete();
        check_status("mid rst", 0, 1'b0, 1'b0);
        check("mid rst rdata", 32'(out_read_data), 32'h0);

        // One-cycle write-to-read latency after reset
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        check_status("post rst", 1, 1'b0, 1'b0);
        check("post rst head", 32'(out_read_data), 32'h77);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("final queue empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO: the next generation of the fixed 4-entry, 8-bit FIFO. It generalises data width and depth, including non-power-of-two depths, and adds programmable almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow error flags. It sits between any producer/consumer pair in one clock domain and is the standard buffering block for new designs.

## Interface
Parameters:
- WIDTH, 8: data width in bits, ≥1
- ENTRIES, 4: depth, ≥2; need not be a power of two
- AFULL_THRESH, ENTRIES-1: out_almost_full asserts when count ≥ this value; 1..ENTRIES
- AEMPTY_THRESH, 1: out_almost_empty asserts when count ≤ this value; 0..ENTRIES-1

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- in_write_ctrl  in  1  push request
- in_write_data  in  WIDTH  push data
- in_read_ctrl  in  1  pop request
- in_clear_err  in  1  clears sticky error flags
- out_read_data  out  WIDTH  head entry, first-word-fall-through
- out_is_full  out  1  count == ENTRIES
- out_is_empty  out  1  count == 0
- out_almost_full  out  1  count ≥ AFULL_THRESH
- out_almost_empty  out  1  count ≤ AEMPTY_THRESH
- out_count  out  CNT_W  occupancy, CNT_W = $clog2(ENTRIES+1)
- out_overflow  out  1  sticky: a push was dropped
- out_underflow  out  1  sticky: a pop was ignored

## Operation
- Accepted push: in_write_ctrl && (!full || in_read_ctrl). It writes mem[write_ptr] and advances write_ptr.
- Accepted pop: in_read_ctrl && !empty. It advances read_ptr.
- Pointers wrap from ENTRIES-1 to 0 by explicit compare, not by modulo-2^n.
- count' = count + push_acc - pop_acc. Never exceeds ENTRIES, never negative.
- Full, with push and pop in the same cycle: both accepted, count unchanged, no overflow.
- Empty, with push and pop in the same cycle: push accepted, pop ignored, count becomes 1, out_underflow set. There is no pass-through.
- Push while full with no pop: data dropped, state unchanged, out_overflow set.
- Pop while empty: ignored, out_underflow set.
- Error flags are sticky. in_clear_err clears both the following cycle. A new error in the same cycle as in_clear_err wins, so the flag stays set.
- out_read_data = mem[read_ptr] when !empty, and all-zero when empty. It is not registered separately.
- All status outputs are decoded from the registered count and pointers only. There is no combinational path from inputs to outputs.

## Timing
- Reset values: count 0, pointers 0, out_is_empty 1, out_is_full 0, out_almost_empty 1, out_almost_full 0, out_overflow 0, out_underflow 0, out_read_data 0. Memory contents are not reset.
- Reset has priority over every other input in the same cycle. Reset during traffic discards all contents; out_is_empty is 1 in the cycle after rst is sampled.
- Write-to-read latency is 1 cycle: data pushed at edge N appears on out_read_data after edge N when the FIFO was empty.
- Pop takes effect at the edge; the next head is visible after that edge.
- All flags and out_count update 1 cycle after the causing edge, consistently with each other.

## Structure
- Package fifo_param_pkg holds:
  - function cnt_width(entries) returning $clog2(entries+1)
  - function ptr_width(entries) returning max(1, $clog2(entries))
  - typedef for the error-flag struct {overflow, underflow}
- One sub-module, fifo_ptr, instantiated twice (read and write): a pointer register with enable, wrap at ENTRIES-1 and synchronous reset.
- Storage is a flat register array. It is not a RAM macro.

## Test plan
- ENTRIES=5, WIDTH=8, AFULL_THRESH=4, AEMPTY_THRESH=1:
  - Push 0x11..0x55 with no pops → out_count steps 1..5, out_almost_full at count 4, out_is_full at 5. Then pop 5 → data 0x11..0x55 in order, out_is_empty set.
  - With the FIFO full, push 0x66 with no pop → out_overflow=1, count stays 5, head still 0x11. Pulse in_clear_err → out_overflow=0 the next cycle.
  - With the FIFO full, push 0xAA and pop in the same cycle → count stays 5, head 0x22, 0xAA last out, no error.
  - With the FIFO empty, push 0x3C and pop in the same cycle → count 1, head 0x3C, out_underflow=1.
  - Run 12 push/pop pairs at count 3 → both pointers wrap twice past index 4 with data intact.
- Reset mid-stream at count 3 → next cycle count 0, out_is_empty=1, out_read_data=0, and both error flags 0.
